// File: rtl/dir_rom_rr_arbiter.sv
// Round-robin arbiter sharing one direction-offset ROM among NREQ requesters.
// Optional DIR_ARB_PIPE_EN adds a request register stage ahead of the ROM (latency 2).
module dir_rom_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_addr,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [4:0]        rsp_data,
    input  logic              rsp_ready
);

    // Sector offset relative to bin 8, wrapped to 5-bit two's complement.
    function automatic logic [4:0] f_rom(input logic [7:0] a);
        return 5'd8 - {1'b0, a[7:4]};
    endfunction

    logic [IDW-1:0] r_rr_ptr;
    logic           r_rsp_valid;
    logic [IDW-1:0] r_rsp_id;
    logic [4:0]     r_rsp_data;

    logic           w_free;
    logic           w_found;
    logic           w_grant;
    logic [IDW-1:0] w_gidx;
    logic [IDW-1:0] w_scan;
    logic [IDW-1:0] w_next_ptr;
    logic [7:0]     w_addr;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_scan  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_scan = IDW'((int'(r_rr_ptr) + k) % NREQ);
            if (!w_found && req_valid[w_scan]) begin
                w_found = 1'b1;
                w_gidx  = w_scan;
            end
        end
    end

    // Address mux uses constant slices; req_addr never reaches req_ready.
    always_comb begin
        w_addr = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_gidx == IDW'(i)) w_addr = req_addr[8*i +: 8];
        end
    end

    assign w_grant    = !rst && w_free && w_found;
    assign w_next_ptr = (w_gidx == IDW'(NREQ-1)) ? '0 : w_gidx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (w_grant) req_ready[w_gidx] = 1'b1;
    end

`ifdef DIR_ARB_PIPE_EN
    logic           r_req_valid;
    logic [IDW-1:0] r_req_id;
    logic [7:0]     r_req_addr;
    logic           w_rsp_adv;

    assign w_rsp_adv = !r_rsp_valid || rsp_ready;
    assign w_free    = !r_req_valid || w_rsp_adv;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_req_valid <= 1'b0;
            r_req_id    <= '0;
            r_req_addr  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_grant) r_rr_ptr <= w_next_ptr;
            if (w_free) begin
                r_req_valid <= w_grant;
                if (w_grant) begin
                    r_req_id   <= w_gidx;
                    r_req_addr <= w_addr;
                end
            end
            if (w_rsp_adv) begin
                r_rsp_valid <= r_req_valid;
                if (r_req_valid) begin
                    r_rsp_id   <= r_req_id;
                    r_rsp_data <= f_rom(r_req_addr);
                end
            end
        end
    end
`else
    assign w_free = !r_rsp_valid || rsp_ready;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            if (w_grant) r_rr_ptr <= w_next_ptr;
            // Drain without grant clears valid but keeps the last id/data.
            if (w_free) begin
                r_rsp_valid <= w_grant;
                if (w_grant) begin
                    r_rsp_id   <= w_gidx;
                    r_rsp_data <= f_rom(w_addr);
                end
            end
        end
    end
`endif

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;

endmodule
